// File: rtl/nibble_serial_adder_16.sv
// nibble_serial_adder_16
//
// 16-bit unsigned adder that works through the operands one nibble per clock,
// using a 4-bit carry-lookahead slice. Operands are latched on the accept
// edge, and the 17-bit result is presented after four nibble steps.
// The result is held until downstream takes it.
//
// Ports
//   i_clk    : clock, all state changes on its rising edge
//   i_rst    : synchronous active-high reset
//   i_valid  : upstream operands valid
//   o_ready  : block can accept operands (IDLE only)
//   i_add1   : operand A, 16-bit unsigned
//   i_add2   : operand B, 16-bit unsigned
//   o_valid  : o_result valid (DONE only)
//   i_ready  : downstream takes the result
//   o_result : {carry_out, sum[15:0]}
//   o_busy   : operation in flight (ADD or DONE)
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for i_valid; operands are accepted on the next edge
// ADD   | one nibble (k = 0..3) is added per edge, LSB nibble first
// DONE  | o_result valid; held until i_ready is seen at an edge

module nibble_serial_adder_16 (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [15:0] i_add1,
    input  logic [15:0] i_add2,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [16:0] o_result,
    output logic        o_busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic [15:0] op_a_q;
    logic [15:0] op_b_q;
    logic [15:0] sum_q;
    logic [16:0] result_q;
    logic [1:0]  k_q;
    logic        carry_q;

    logic [3:0]  nib_a;
    logic [3:0]  nib_b;
    logic [3:0]  nib_g;
    logic [3:0]  nib_p;
    logic [4:0]  nib_c;
    logic [3:0]  nib_sum;

    // Carry-lookahead slice for the current nibble. Carries are written in
    // flattened form so that each one depends only on g/p and the carry-in.
    always_comb begin
        nib_a    = op_a_q[{k_q, 2'b00} +: 4];
        nib_b    = op_b_q[{k_q, 2'b00} +: 4];
        nib_g    = nib_a & nib_b;
        nib_p    = nib_a | nib_b;
        nib_c[0] = carry_q;
        nib_c[1] = nib_g[0] | (nib_p[0] & carry_q);
        nib_c[2] = nib_g[1] | (nib_p[1] & nib_g[0])
                 | (nib_p[1] & nib_p[0] & carry_q);
        nib_c[3] = nib_g[2] | (nib_p[2] & nib_g[1])
                 | (nib_p[2] & nib_p[1] & nib_g[0])
                 | (nib_p[2] & nib_p[1] & nib_p[0] & carry_q);
        nib_c[4] = nib_g[3] | (nib_p[3] & nib_g[2])
                 | (nib_p[3] & nib_p[2] & nib_g[1])
                 | (nib_p[3] & nib_p[2] & nib_p[1] & nib_g[0])
                 | (nib_p[3] & nib_p[2] & nib_p[1] & nib_p[0] & carry_q);
        nib_sum  = nib_a ^ nib_b ^ nib_c[3:0];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        o_ready = 1'b0;
        o_valid = 1'b0;
        o_busy  = 1'b0;
        case (state_q)
            IDLE: begin
                o_ready = 1'b1;
                if (i_valid) begin
                    state_d = ADD;
                end
            end
            ADD: begin
                o_busy = 1'b1;
                if (k_q == 2'd3) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                o_busy  = 1'b1;
                o_valid = 1'b1;
                if (i_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            op_a_q   <= '0;
            op_b_q   <= '0;
            sum_q    <= '0;
            result_q <= '0;
            k_q      <= '0;
            carry_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_valid) begin
                        op_a_q  <= i_add1;
                        op_b_q  <= i_add2;
                        sum_q   <= '0;
                        k_q     <= '0;
                        carry_q <= 1'b0;
                    end
                end
                ADD: begin
                    sum_q[{k_q, 2'b00} +: 4] <= nib_sum;
                    carry_q                  <= nib_c[4];
                    k_q                      <= k_q + 2'd1;
                    // Last nibble: the visible result is built directly
                    // from the slice output, since sum_q updates on this
                    // same edge.
                    if (k_q == 2'd3) begin
                        result_q <= {nib_c[4], nib_sum, sum_q[11:0]};
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_result = result_q;

endmodule

// File: tb/tb_nibble_serial_adder_16.sv
module tb_nibble_serial_adder_16;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic        o_ready;
    logic [15:0] i_add1;
    logic [15:0] i_add2;
    logic        o_valid;
    logic        i_ready;
    logic [16:0] o_result;
    logic        o_busy;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    always #5 i_clk = ~i_clk;

    nibble_serial_adder_16 dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_add1  (i_add1),
        .i_add2  (i_add2),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_result(o_result),
        .o_busy  (o_busy)
    );

    function automatic logic [31:0] model_sum(input logic [15:0] a, input logic [15:0] b);
        int unsigned s;
        s = int'(a) + int'(b);
        return 32'(s);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
        cyc++;
    endtask

    // One complete operation. stall = extra DONE cycles with i_ready low;
    // noise = drive i_valid and fresh operands while the add is in flight.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input int stall, input bit noise);
        int          n;
        logic [31:0] exp;
        exp = model_sum(a, b);
        n = 0;
        while (!o_ready && n < 20) begin
            tick();
            n++;
        end
        check("ready_before_accept", 32'(o_ready), 32'd1);
        i_valid = 1'b1;
        i_add1  = a;
        i_add2  = b;
        i_ready = (stall == 0);
        tick();
        i_valid = noise;
        if (noise) begin
            i_add1 = 16'($urandom);
            i_add2 = 16'($urandom);
        end
        check("busy_in_add", 32'(o_busy), 32'd1);
        check("ready_low_in_add", 32'(o_ready), 32'd0);
        n = 0;
        while (!o_valid && n < 10) begin
            tick();
            n++;
            if (noise) begin
                i_add1 = 16'($urandom);
                i_add2 = 16'($urandom);
            end
        end
        i_valid = 1'b0;
        check("latency", 32'(n), 32'd4);
        check("result", 32'(o_result), exp);
        for (int i = 0; i < stall; i++) begin
            tick();
            check("stall_valid_held", 32'(o_valid), 32'd1);
            check("stall_result_held", 32'(o_result), exp);
        end
        i_ready = 1'b1;
        tick();
        check("valid_drops", 32'(o_valid), 32'd0);
        check("ready_after_done", 32'(o_ready), 32'd1);
        check("result_kept_idle", 32'(o_result), exp);
        if (noise) begin
            tick();
            tick();
            check("no_second_result", 32'({o_busy, o_valid}), 32'd0);
        end
    endtask

    initial begin
        int          n;
        int          t0;
        logic        seen;
        logic [15:0] ra;
        logic [15:0] rb;

        i_rst   = 1'b1;
        i_valid = 1'b1;
        i_add1  = 16'h1111;
        i_add2  = 16'h2222;
        i_ready = 1'b0;
        tick();
        tick();
        check("rst_ready", 32'(o_ready), 32'd1);
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_result", 32'(o_result), 32'd0);
        i_rst   = 1'b0;
        i_valid = 1'b0;
        tick();

        run_op(16'h1234, 16'h4321, 0, 1'b0);
        run_op(16'hFFFF, 16'h0001, 0, 1'b0);
        run_op(16'hFFFF, 16'hFFFF, 0, 1'b0);
        run_op(16'h00F0, 16'h0010, 3, 1'b0);
        run_op(16'hA5A5, 16'h5A5A, 1, 1'b1);
        run_op(16'h0000, 16'h0000, 0, 1'b0);

        // Reset arriving on the 2nd ADD edge aborts the operation.
        i_valid = 1'b1;
        i_add1  = 16'h7777;
        i_add2  = 16'h9999;
        i_ready = 1'b1;
        tick();
        i_valid = 1'b0;
        tick();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        check("abort_ready", 32'(o_ready), 32'd1);
        check("abort_valid", 32'(o_valid), 32'd0);
        check("abort_busy", 32'(o_busy), 32'd0);
        check("abort_result", 32'(o_result), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            seen = seen | o_valid | o_busy;
        end
        check("abort_no_result", 32'(seen), 32'd0);

        // Back-to-back with i_valid held high.
        i_ready = 1'b1;
        i_valid = 1'b1;
        i_add1  = 16'h0001;
        i_add2  = 16'h0001;
        tick();
        t0 = cyc;
        i_add1 = 16'h8000;
        i_add2 = 16'h8000;
        n = 0;
        while (!o_valid && n < 10) begin
            tick();
            n++;
        end
        check("b2b_first", 32'(o_result), model_sum(16'h0001, 16'h0001));
        n = 0;
        while (o_busy && n < 10) begin
            tick();
            n++;
        end
        n = 0;
        while (!o_busy && n < 10) begin
            tick();
            n++;
        end
        check("b2b_spacing", 32'(cyc - t0), 32'd6);
        i_valid = 1'b0;
        n = 0;
        while (!o_valid && n < 10) begin
            tick();
            n++;
        end
        check("b2b_second", 32'(o_result), model_sum(16'h8000, 16'h8000));
        tick();

        for (int i = 0; i < 24; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            run_op(ra, rb, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
